// File: rtl/seq_rotate_right_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_rotate_right_pkg : opcodes, FSM states and helpers shared by the  |
// | multi-cycle right rotate/shift unit.            Rev 1.0               |
// +----------------------------------------------------------------------+
package seq_rotate_right_pkg;

  localparam logic [1:0] OP_ROR = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Bit shifted in from the top: sign for SRA, zero for everything else.
  function automatic logic fill_bit(input logic [1:0] op, input logic msb);
    return (op == OP_SRA) ? msb : 1'b0;
  endfunction

endpackage : seq_rotate_right_pkg
`default_nettype wire

// File: rtl/seq_rotate_right_rr_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_stage : one combinational right rotate/shift stage; the amount is  |
// | 2**(CNT_W-1-sel), so stage 0 moves by the largest power of two.       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module rr_stage
  import seq_rotate_right_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4,
  parameter int STG_W = 2
) (
  input  logic [WIDTH-1:0] d,
  input  logic [STG_W-1:0] sel,
  input  logic [1:0]       op,
  input  logic             fill,
  output logic [WIDTH-1:0] d_next
);

  localparam logic [CNT_W:0] c_width = (CNT_W+1)'(WIDTH);

  logic [STG_W-1:0] w_pow;
  logic [CNT_W:0]   w_amt;
  logic [CNT_W:0]   w_lsh;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_shf;

  assign w_pow = STG_W'(CNT_W - 1) - sel;
  assign w_amt = (CNT_W+1)'(1) << w_pow;
  assign w_lsh = c_width - w_amt;

  assign w_ror = (d >> w_amt) | (d << w_lsh);
  assign w_shf = (d >> w_amt) | (~({WIDTH{1'b1}} >> w_amt) & {WIDTH{fill}});

  always_comb begin
    d_next = d;
    unique case (op)
      OP_ROR:         d_next = w_ror;
      OP_SRL, OP_SRA: d_next = w_shf;
      default:        d_next = d;
    endcase
  end

endmodule : rr_stage
`default_nettype wire

// File: rtl/seq_rotate_right.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_rotate_right : multi-cycle ROR/SRL/SRA unit, one count bit per    |
// | cycle through a single shared stage, valid/ready on both sides.       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module seq_rotate_right
  import seq_rotate_right_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0] cnt,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             err
);

  localparam int STG_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam logic [STG_W-1:0] c_last_stage = STG_W'(CNT_W - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [STG_W-1:0] r_stage;
  logic [WIDTH-1:0] r_d;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic             r_fill;
  logic [WIDTH-1:0] r_dout;
  logic             r_err;

  logic             w_last;
  logic [STG_W-1:0] w_bit_idx;
  logic             w_take;
  logic [WIDTH-1:0] w_stage_out;
  logic [WIDTH-1:0] w_d_next;

  assign w_last    = (r_stage == c_last_stage);
  assign w_bit_idx = c_last_stage - r_stage;
  assign w_take    = r_cnt[w_bit_idx];
  assign w_d_next  = w_take ? w_stage_out : r_d;

  rr_stage #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W),
    .STG_W (STG_W)
  ) u_stage (
    .d      (r_d),
    .sel    (r_stage),
    .op     (r_op),
    .fill   (r_fill),
    .d_next (w_stage_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: if (in_valid)  w_state_nxt = ST_BUSY;
        ST_BUSY: if (w_last)    w_state_nxt = ST_DONE;
        ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
        default:                w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Result and err are captured on the final stage edge so they stay
  // stable through DONE and after the drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_op    <= '0;
      r_fill  <= 1'b0;
      r_dout  <= '0;
      r_err   <= 1'b0;
    end else if (flush) begin
      r_stage <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_d     <= data_in;
            r_cnt   <= cnt;
            r_op    <= op;
            r_fill  <= fill_bit(op, data_in[WIDTH-1]);
            r_stage <= '0;
            r_err   <= 1'b0;
          end
        end
        ST_BUSY: begin
          r_d     <= w_d_next;
          r_stage <= r_stage + STG_W'(1);
          if (w_last) begin
            r_dout <= w_d_next;
            r_err  <= (r_op == OP_ILL);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign data_out  = r_dout;
  assign err       = r_err;

endmodule : seq_rotate_right
`default_nettype wire

// File: tb/tb_seq_rotate_right.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seq_rotate_right : vector table, hand-written corner sequences and |
// | randomized ops against a bit-level reference model.    Rev 1.0       |
// +----------------------------------------------------------------------+
module tb_seq_rotate_right;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_in;
  logic [3:0]  cnt;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] data_out;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  seq_rotate_right #(.WIDTH(16), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .cnt       (cnt),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  c;
    logic [1:0]  o;
    logic [15:0] ed;
    logic        ee;
    string       nm;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Bit-level reference: ROR n is a left rotate by (16-n)%16.
  function automatic logic [16:0] model(input logic [15:0] d, input logic [3:0] n,
                                        input logic [1:0] o);
    logic [15:0] r;
    int          l;
    int          s;
    r = '0;
    s = int'(n);
    case (o)
      2'b00: begin
        l = (16 - s) % 16;
        for (int i = 0; i < 16; i++) r[(i + l) % 16] = d[i];
      end
      2'b01: for (int i = 0; i < 16; i++) r[i] = (i + s < 16) ? d[i + s] : 1'b0;
      2'b10: for (int i = 0; i < 16; i++) r[i] = (i + s < 16) ? d[i + s] : d[15];
      default: r = d;
    endcase
    return {(o == 2'b11), r};
  endfunction

  // Called ~1 time unit after a rising edge; returns ~1 unit after the accept edge.
  task automatic accept_op(input logic [15:0] d, input logic [3:0] c, input logic [1:0] o,
                           input string nm);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    data_in  = d;
    cnt      = c;
    op       = o;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in  = 16'($urandom);
    cnt      = 4'($urandom);
    op       = 2'($urandom);
  endtask

  task automatic wait_result(input logic [15:0] ed, input logic ee, input string nm);
    int lat;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk({nm, "_latency"}, 32'(lat), 32'd4);
    chk({nm, "_data"}, 32'(data_out), 32'(ed));
    chk({nm, "_err"}, 32'(err), 32'(ee));
  endtask

  task automatic drain(input int hold, input string nm);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_drain"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    logic [16:0] exp_v;
    logic [15:0] rd;
    logic [3:0]  rc;
    logic [1:0]  ro;

    vecs[0] = '{16'h1234, 4'd4,  2'b00, 16'h4123, 1'b0, "ror_1234_4"};
    vecs[1] = '{16'h8000, 4'd15, 2'b10, 16'hFFFF, 1'b0, "sra_8000_15"};
    vecs[2] = '{16'h8000, 4'd15, 2'b01, 16'h0001, 1'b0, "srl_8000_15"};
    vecs[3] = '{16'h7FFF, 4'd1,  2'b10, 16'h3FFF, 1'b0, "sra_7fff_1"};
    vecs[4] = '{16'hA5A5, 4'd0,  2'b00, 16'hA5A5, 1'b0, "ror_a5a5_0"};
    vecs[5] = '{16'hBEEF, 4'd7,  2'b11, 16'hBEEF, 1'b1, "ill_beef_7"};
    vecs[6] = '{16'h0001, 4'd1,  2'b00, 16'h8000, 1'b0, "ror_0001_1"};
    vecs[7] = '{16'h1234, 4'd4,  2'b01, 16'h0123, 1'b0, "srl_1234_4"};
    vecs[8] = '{16'hF000, 4'd4,  2'b10, 16'hFF00, 1'b0, "sra_f000_4"};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    data_in = '0; cnt = '0; op = '0;
    #2;
    chk("reset_outputs", {13'd0, in_ready, out_valid, err, data_out}, {13'd0, 1'b1, 1'b0, 1'b0, 16'h0});
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      accept_op(vecs[i].d, vecs[i].c, vecs[i].o, vecs[i].nm);
      wait_result(vecs[i].ed, vecs[i].ee, vecs[i].nm);
      drain(0, vecs[i].nm);
    end

    // Stall in DONE while upstream keeps poking in_valid.
    accept_op(16'h1234, 4'd4, 2'b00, "stall");
    wait_result(16'h4123, 1'b0, "stall");
    for (int k = 0; k < 3; k++) begin
      in_valid = ~in_valid;
      data_in  = 16'($urandom);
      op       = 2'b01;
      @(posedge clk); #1;
      chk("stall_hold", {14'd0, out_valid, in_ready, data_out}, {14'd0, 1'b1, 1'b0, 16'h4123});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stall_release", {14'd0, out_valid, in_ready, data_out}, {14'd0, 1'b0, 1'b1, 16'h4123});

    // Asynchronous reset in the middle of BUSY.
    accept_op(16'h00F0, 4'd3, 2'b00, "rst_busy");
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rst_busy_async", {14'd0, out_valid, in_ready, data_out}, {14'd0, 1'b0, 1'b1, 16'h0});
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Flush in BUSY, then a fresh op.
    accept_op(16'h8000, 4'd15, 2'b10, "flush_busy");
    @(posedge clk); @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy_idle", {30'd0, out_valid, in_ready}, 32'b01);
    accept_op(16'h0001, 4'd1, 2'b00, "after_flush");
    wait_result(16'h8000, 1'b0, "after_flush");
    drain(0, "after_flush");

    // Flush beats out_ready in DONE; err clears, data_out is kept.
    accept_op(16'hBEEF, 4'd7, 2'b11, "flush_done");
    wait_result(16'hBEEF, 1'b1, "flush_done");
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_done_state", {13'd0, in_ready, out_valid, err, data_out}, {13'd0, 1'b1, 1'b0, 1'b0, 16'hBEEF});

    for (int n = 0; n < 2000; n++) begin
      rd = 16'($urandom);
      rc = 4'($urandom);
      ro = 2'($urandom);
      exp_v = model(rd, rc, ro);
      accept_op(rd, rc, ro, "rand");
      wait_result(exp_v[15:0], exp_v[16], "rand");
      drain(int'($urandom_range(0, 2)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_seq_rotate_right
`default_nettype wire
